// File: rtl/axis_pkg.sv
// Shared constants and helpers for the AXI-Stream FIFO.
// Pointer width carries one extra bit so that full and empty can be told apart.
package axis_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 16;

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read gives first-word fall-through from the head pointer.
   assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo.sv
// First-word fall-through AXI-Stream FIFO with occupancy count, flush and sticky overflow.
// Readiness is derived only from registered pointers, so no ready-to-ready combinational path exists.
module axis_fifo
   import axis_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic [WIDTH-1:0]             s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   output logic [WIDTH-1:0]             m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   input  logic                         flush,
   output logic [ptr_width(DEPTH)-1:0]  count,
   output logic                         overflow
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   logic [PW-1:0] level;
   logic          full, empty, wr_en, rd_en;

   // Pointers wrap modulo 2*DEPTH, so the difference is the occupancy directly.
   assign level = wr_ptr_q - rd_ptr_q;
   assign full  = (level == PW'(DEPTH));
   assign empty = (level == '0);

   always_comb begin
      wr_en      = s_axis_tvalid && !full && !flush;
      rd_en      = m_axis_tready && !empty && !flush;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q | (s_axis_tvalid & full);
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (aclk),
      .we    (wr_en),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (s_axis_tdata),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (m_axis_tdata)
   );

   assign s_axis_tready = !full;
   assign m_axis_tvalid = !empty;
   assign count         = level;
   assign overflow      = overflow_q;

endmodule

// File: doc/axis_fifo.md
AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 Parameter WIDTH, default 32, is the data word width in bits.
REQ-002 Parameter DEPTH, default 16, is the number of storage entries; it SHALL be a power of two and at least 2.
REQ-003 Port aclk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-004 Port areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port s_axis_tdata, input, WIDTH bits: write-side data from the AXI-lite-to-stream bridge's m_axis_wdata.
REQ-006 Port s_axis_tvalid, input, 1 bit: write-side valid.
REQ-007 Port s_axis_tready, output, 1 bit: write-side ready.
REQ-008 Port m_axis_tdata, output, WIDTH bits: read-side data to the peripheral.
REQ-009 Port m_axis_tvalid, output, 1 bit: read-side valid.
REQ-010 Port m_axis_tready, input, 1 bit: read-side ready.
REQ-011 Port flush, input, 1 bit: synchronous discard of all stored words.
REQ-012 Port count, output, log2(DEPTH)+1 bits: number of stored words, readable by software as the pending count.
REQ-013 Port overflow, output, 1 bit: sticky flag for a write attempted while full.

Function
REQ-014 A write SHALL occur on a cycle with s_axis_tvalid and s_axis_tready both high; a read SHALL occur on a cycle with m_axis_tvalid and m_axis_tready both high.
REQ-015 s_axis_tready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on m_axis_tready.
REQ-016 m_axis_tvalid SHALL equal (count != 0); m_axis_tdata SHALL present the oldest stored word (first-word fall-through).
REQ-017 A word written in cycle N SHALL first be visible on m_axis_tdata with m_axis_tvalid high in cycle N+1 when the FIFO was empty; there SHALL be no same-cycle bypass.
REQ-018 Words SHALL be delivered in write order, with no loss or duplication.
REQ-019 Write and read pointers SHALL be log2(DEPTH)+1 bits wide; the MSB distinguishes full from empty, and the pointers SHALL wrap modulo 2*DEPTH.
REQ-020 count SHALL equal write pointer minus read pointer, modulo 2*DEPTH.
REQ-021 A simultaneous write and read with 0 < count < DEPTH SHALL leave count unchanged.
REQ-022 When full, a read in a cycle SHALL NOT allow a write in that same cycle; s_axis_tready SHALL rise the cycle after the read.
REQ-023 When empty, m_axis_tready SHALL have no effect.
REQ-024 overflow SHALL set in the cycle after s_axis_tvalid is high while count == DEPTH; it SHALL clear only on reset or flush.
REQ-025 flush high SHALL set both pointers to 0 and clear overflow at the next edge; a write or read in the same cycle SHALL be ignored.
REQ-026 m_axis_tvalid and m_axis_tdata SHALL remain stable while m_axis_tready is low, apart from flush or reset.

Reset
REQ-027 While areset is high, pointers SHALL be 0 and overflow SHALL be 0, giving count 0, s_axis_tready 1 and m_axis_tvalid 0 without waiting for a clock edge.
REQ-028 Storage contents SHALL NOT be reset; m_axis_tdata is don't-care while m_axis_tvalid is 0.
REQ-029 Reset asserted mid-transfer SHALL discard all stored words; the first write after release SHALL be the first word read.

Structure
REQ-030 The shared package axis_pkg SHALL hold the default WIDTH and DEPTH constants and a pointer-width function clog2-based.
REQ-031 Storage SHALL be a sub-module fifo_ram: 1 write port, 1 asynchronous read port, DEPTH x WIDTH, with no reset.
REQ-032 Pointer, count and flag logic SHALL reside in axis_fifo.

Verification
REQ-033 Write 0x11, 0x22, 0x33 with m_axis_tready=0, then raise m_axis_tready -> reads are 0x11, 0x22, 0x33 in order, and count goes 3,2,1,0.
REQ-034 Write 16 words 0x0..0xF into a DEPTH=16 FIFO -> s_axis_tready=0 and count=16; a 17th write attempt -> overflow=1 and the data is unchanged.
REQ-035 Hold both sides active at count=5 for 40 cycles -> count stays 5, and pointers wrap past 32 without error.
REQ-036 Full FIFO with one read and one write offered in the same cycle -> the write is refused that cycle, s_axis_tready=1 the next cycle, and count=15.
REQ-037 With count=7, assert flush together with a write -> count=0, m_axis_tvalid=0, overflow=0, and the flushed write is absent.
REQ-038 Assert areset asynchronously mid-stream at count=4 -> count=0 and m_axis_tvalid=0 immediately; after release, write 0xAB -> 0xAB is read first.
